// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stalls, branch redirect and flush.
// Define PERF_CNT_EN to build the stall/flush performance counters; otherwise they read as 0.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL    = 1,
    parameter int unsigned REDIRECT_HOLD = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rdest,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rdest,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rdest,
    input  logic             wb_regwrite,
    input  logic             br_taken,
    input  logic [7:0]       br_target,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             exmem_flush,
    output logic             pc_sel,
    output logic [7:0]       pc_target,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             busy
);
    typedef enum logic [1:0] {StRun, StStall, StHold} state_e;

    // STALL is entered after the first bubble cycle, so it counts LOAD_STALL-1 more cycles.
    localparam logic [2:0] ScntInit = (LOAD_STALL > 1) ? 3'(LOAD_STALL - 2) : 3'd0;
    localparam logic [2:0] HcntInit = 3'(REDIRECT_HOLD - 1);

    state_e     state_q;
    logic [2:0] scnt_q;
    logic [2:0] hcnt_q;
    logic       lu;
    logic       redirect;
    logic       stalling;

    always_comb begin
        forward_a = 2'b00;
        if (mem_regwrite && mem_rdest != 5'd0 && mem_rdest == ex_rs) begin
            forward_a = 2'b01;
        end else if (wb_regwrite && wb_rdest != 5'd0 && wb_rdest == ex_rs) begin
            forward_a = 2'b10;
        end
        forward_b = 2'b00;
        if (mem_regwrite && mem_rdest != 5'd0 && mem_rdest == ex_rt) begin
            forward_b = 2'b01;
        end else if (wb_regwrite && wb_rdest != 5'd0 && wb_rdest == ex_rt) begin
            forward_b = 2'b10;
        end
    end

    assign lu = id_valid && ex_memread && ex_rdest != 5'd0 &&
                (ex_rdest == id_rs || ex_rdest == id_rt);

    // A taken branch outranks any stall; during HOLD both branch and lu are ignored.
    assign redirect = br_taken && state_q != StHold;
    assign stalling = !redirect && ((state_q == StRun && lu) || state_q == StStall);

    assign pc_write    = !stalling;
    assign ifid_write  = !stalling;
    assign idex_bubble = redirect || stalling;
    assign ifid_flush  = redirect;
    assign exmem_flush = redirect;
    assign pc_sel      = redirect;
    assign pc_target   = redirect ? br_target : 8'h00;
    assign busy        = state_q != StRun;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            scnt_q  <= 3'd0;
            hcnt_q  <= 3'd0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (br_taken) begin
                        state_q <= StHold;
                        hcnt_q  <= HcntInit;
                    end else if (lu && LOAD_STALL > 1) begin
                        state_q <= StStall;
                        scnt_q  <= ScntInit;
                    end
                end
                StStall: begin
                    if (br_taken) begin
                        state_q <= StHold;
                        hcnt_q  <= HcntInit;
                    end else if (scnt_q == 3'd0) begin
                        state_q <= StRun;
                    end else begin
                        scnt_q <= scnt_q - 3'd1;
                    end
                end
                StHold: begin
                    if (hcnt_q == 3'd0) begin
                        state_q <= StRun;
                    end else begin
                        hcnt_q <= hcnt_q - 3'd1;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stalling && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (redirect && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (LOAD_STALL=1/HOLD=1 and LOAD_STALL=3/HOLD=2
// with 2-bit counters so saturation is reached).
module tb_hazard_ctrl;
`ifdef PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, ex_memread, mem_regwrite, wb_regwrite, br_taken;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rdest, mem_rdest, wb_rdest;
    logic [7:0] br_target;

    logic        pc_write_1, ifid_write_1, idex_bubble_1, ifid_flush_1, exmem_flush_1;
    logic        pc_sel_1, busy_1;
    logic [7:0]  pc_target_1;
    logic [1:0]  forward_a_1, forward_b_1;
    logic [15:0] stall_cnt_1, flush_cnt_1;

    logic        pc_write_3, ifid_write_3, idex_bubble_3, ifid_flush_3, exmem_flush_3;
    logic        pc_sel_3, busy_3;
    logic [7:0]  pc_target_3;
    logic [1:0]  forward_a_3, forward_b_3;
    logic [1:0]  stall_cnt_3, flush_cnt_3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL(1), .REDIRECT_HOLD(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rdest(ex_rdest), .ex_memread(ex_memread),
        .mem_rdest(mem_rdest), .mem_regwrite(mem_regwrite), .wb_rdest(wb_rdest),
        .wb_regwrite(wb_regwrite), .br_taken(br_taken), .br_target(br_target),
        .pc_write(pc_write_1), .ifid_write(ifid_write_1), .idex_bubble(idex_bubble_1),
        .ifid_flush(ifid_flush_1), .exmem_flush(exmem_flush_1), .pc_sel(pc_sel_1),
        .pc_target(pc_target_1), .forward_a(forward_a_1), .forward_b(forward_b_1),
        .stall_cnt(stall_cnt_1), .flush_cnt(flush_cnt_1), .busy(busy_1)
    );

    hazard_ctrl #(.LOAD_STALL(3), .REDIRECT_HOLD(2), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rdest(ex_rdest), .ex_memread(ex_memread),
        .mem_rdest(mem_rdest), .mem_regwrite(mem_regwrite), .wb_rdest(wb_rdest),
        .wb_regwrite(wb_regwrite), .br_taken(br_taken), .br_target(br_target),
        .pc_write(pc_write_3), .ifid_write(ifid_write_3), .idex_bubble(idex_bubble_3),
        .ifid_flush(ifid_flush_3), .exmem_flush(exmem_flush_3), .pc_sel(pc_sel_3),
        .pc_target(pc_target_3), .forward_a(forward_a_3), .forward_b(forward_b_3),
        .stall_cnt(stall_cnt_3), .flush_cnt(flush_cnt_3), .busy(busy_3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected counter value: counters read 0 when not built.
    function automatic logic [31:0] cexp(input int n);
        return Perf ? 32'(n) : 32'd0;
    endfunction

    // Control vector order: pc_write, ifid_write, idex_bubble, 3 flushes/pc_sel, busy.
    function automatic logic [31:0] cv(input bit pw, input bit iw, input bit bub, input bit fl,
                                       input bit bsy);
        return {25'd0, pw, iw, bub, fl, fl, fl, bsy};
    endfunction

    task automatic ctrl1(input string tag, input logic [31:0] exp, input logic [7:0] tgt);
        chk({tag, "_ctl1"}, {25'd0, pc_write_1, ifid_write_1, idex_bubble_1, ifid_flush_1,
                              exmem_flush_1, pc_sel_1, busy_1}, exp);
        chk({tag, "_tgt1"}, {24'd0, pc_target_1}, {24'd0, tgt});
    endtask

    task automatic ctrl3(input string tag, input logic [31:0] exp, input logic [7:0] tgt);
        chk({tag, "_ctl3"}, {25'd0, pc_write_3, ifid_write_3, idex_bubble_3, ifid_flush_3,
                              exmem_flush_3, pc_sel_3, busy_3}, exp);
        chk({tag, "_tgt3"}, {24'd0, pc_target_3}, {24'd0, tgt});
    endtask

    task automatic cnts(input string tag, input int s1, input int f1, input int s3,
                        input int f3);
        chk({tag, "_stall1"}, {16'd0, stall_cnt_1}, cexp(s1));
        chk({tag, "_flush1"}, {16'd0, flush_cnt_1}, cexp(f1));
        chk({tag, "_stall3"}, {30'd0, stall_cnt_3}, cexp(s3));
        chk({tag, "_flush3"}, {30'd0, flush_cnt_3}, cexp(f3));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input bit on);
        id_valid   = on;
        ex_memread = on;
        id_rs      = 5'd1;
        id_rt      = 5'd5;
        ex_rdest   = 5'd5;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; ex_memread = 0; mem_regwrite = 0; wb_regwrite = 0; br_taken = 0;
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rdest = 0;
        mem_rdest = 0; wb_rdest = 0; br_target = 8'h00;
        tick();
        tick();
        ctrl1("reset", cv(1, 1, 0, 0, 0), 8'h00);
        ctrl3("reset", cv(1, 1, 0, 0, 0), 8'h00);
        chk("reset_fwd", {28'd0, forward_a_1, forward_b_1}, 32'd0);
        cnts("reset", 0, 0, 0, 0);
        rst = 1'b0;

        // Forwarding priority
        ex_rs = 5'd3; ex_rt = 5'd7;
        mem_rdest = 5'd3; mem_regwrite = 1; wb_rdest = 5'd3; wb_regwrite = 1;
        #1;
        chk("fwd_a_mem", {30'd0, forward_a_1}, 32'd1);
        chk("fwd_b_none", {30'd0, forward_b_1}, 32'd0);
        chk("fwd_a_mem3", {30'd0, forward_a_3}, 32'd1);
        mem_regwrite = 0;
        #1;
        chk("fwd_a_wb", {30'd0, forward_a_1}, 32'd2);
        mem_regwrite = 1; mem_rdest = 5'd0; wb_rdest = 5'd0; ex_rs = 5'd0;
        #1;
        chk("fwd_a_r0", {30'd0, forward_a_1}, 32'd0);
        ex_rt = 5'd9; mem_rdest = 5'd9; wb_rdest = 5'd9;
        #1;
        chk("fwd_b_mem", {30'd0, forward_b_3}, 32'd1);
        mem_rdest = 5'd4;
        #1;
        chk("fwd_b_wb", {30'd0, forward_b_1}, 32'd2);
        mem_regwrite = 0; wb_regwrite = 0; ex_rt = 0; mem_rdest = 0; wb_rdest = 0;

        // ex_rdest == 0 never causes a load-use stall
        set_lu(1); ex_rdest = 5'd0; id_rs = 5'd0;
        #1;
        ctrl1("lu_r0", cv(1, 1, 0, 0, 0), 8'h00);

        // Load-use: 1 bubble on dut1, 3 bubbles on dut3
        set_lu(1);
        #1;
        ctrl1("lu_c1", cv(0, 0, 1, 0, 0), 8'h00);
        ctrl3("lu_c1", cv(0, 0, 1, 0, 0), 8'h00);
        tick();
        set_lu(0);
        #1;
        ctrl1("lu_c2", cv(1, 1, 0, 0, 0), 8'h00);
        ctrl3("lu_c2", cv(0, 0, 1, 0, 1), 8'h00);
        cnts("lu_c2", 1, 0, 1, 0);
        tick();
        ctrl3("lu_c3", cv(0, 0, 1, 0, 1), 8'h00);
        tick();
        ctrl3("lu_c4", cv(1, 1, 0, 0, 0), 8'h00);
        cnts("lu_c4", 1, 0, 3, 0);

        // Taken branch in RUN, then an ignored br_taken and lu during HOLD
        br_taken = 1; br_target = 8'h02;
        #1;
        ctrl1("br_run", cv(1, 1, 1, 1, 0), 8'h02);
        ctrl3("br_run", cv(1, 1, 1, 1, 0), 8'h02);
        tick();
        br_target = 8'h55; set_lu(1);
        #1;
        ctrl1("br_hold", cv(1, 1, 0, 0, 1), 8'h00);
        ctrl3("br_hold", cv(1, 1, 0, 0, 1), 8'h00);
        cnts("br_hold", 1, 1, 3, 1);
        tick();
        br_taken = 0; set_lu(0);
        #1;
        ctrl1("br_after", cv(1, 1, 0, 0, 0), 8'h00);
        ctrl3("br_hold2", cv(1, 1, 0, 0, 1), 8'h00);
        cnts("br_after", 1, 1, 3, 1);
        tick();
        ctrl3("br_after", cv(1, 1, 0, 0, 0), 8'h00);

        // Branch in the second STALL cycle of dut3 aborts the stall
        set_lu(1);
        tick();
        set_lu(0); br_taken = 1; br_target = 8'hA7;
        #1;
        ctrl3("stbr", cv(1, 1, 1, 1, 1), 8'hA7);
        ctrl1("stbr", cv(1, 1, 1, 1, 0), 8'hA7);
        tick();
        br_taken = 0;
        #1;
        ctrl3("stbr_hold", cv(1, 1, 0, 0, 1), 8'h00);
        cnts("stbr", 2, 2, 3, 2);  // dut3 stall_cnt saturated at 3
        tick();
        tick();
        ctrl3("stbr_run", cv(1, 1, 0, 0, 0), 8'h00);

        // Synchronous reset while dut3 is in STALL
        set_lu(1);
        tick();
        set_lu(0); rst = 1;
        #1;
        ctrl3("rst_stall", cv(0, 0, 1, 0, 1), 8'h00);
        tick();
        rst = 0;
        #1;
        ctrl3("rst_after", cv(1, 1, 0, 0, 0), 8'h00);
        cnts("rst_after", 0, 0, 0, 0);
        tick();
        ctrl3("rst_run", cv(1, 1, 0, 0, 0), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
